// File: rtl/qam_pkg.sv
// Shared definitions for the QAM datapath (mapper, serializer, DAC stage).
// Holds the default sample geometry and the serializer state encoding.
package qam_pkg;

    localparam int QAM_MOD_OUT_WIDTH   = 8;
    localparam int QAM_PIPELINE_DEEPTH = 16;

    function automatic int lane_width(input int mod_out_width);
        return 2 * mod_out_width;
    endfunction

    function automatic int lane_cnt_width(input int pipeline_deepth);
        return $clog2(pipeline_deepth);
    endfunction

    localparam int LANE_W = lane_width(QAM_MOD_OUT_WIDTH);
    localparam int CNT_W  = lane_cnt_width(QAM_PIPELINE_DEEPTH);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

endpackage

// File: rtl/qam_symbol_serializer.sv
// Wide-to-narrow Avalon-ST serializer: one beat of PIPELINE_DEEPTH I/Q lanes in,
// one lane per cycle out (lane 0 first), with packet framing and backpressure.
module qam_symbol_serializer
    import qam_pkg::*;
#(
    parameter int MOD_OUT_WIDTH   = QAM_MOD_OUT_WIDTH,
    parameter int PIPELINE_DEEPTH = QAM_PIPELINE_DEEPTH
) (
    input  logic                                     clock_clk,
    input  logic                                     reset_reset_n,
    input  logic [PIPELINE_DEEPTH*2*MOD_OUT_WIDTH-1:0] asi_in0_data,
    input  logic                                     asi_in0_valid,
    output logic                                     asi_in0_ready,
    input  logic                                     asi_in0_startofpacket,
    input  logic                                     asi_in0_endofpacket,
    output logic [2*MOD_OUT_WIDTH-1:0]               aso_out0_data,
    output logic                                     aso_out0_valid,
    input  logic                                     aso_out0_ready,
    output logic                                     aso_out0_startofpacket,
    output logic                                     aso_out0_endofpacket
);

    localparam int LANE_BITS = lane_width(MOD_OUT_WIDTH);
    localparam int CNT_BITS  = lane_cnt_width(PIPELINE_DEEPTH);
    localparam int BEAT_BITS = PIPELINE_DEEPTH * LANE_BITS;
    localparam logic [CNT_BITS-1:0] LAST_LANE = CNT_BITS'(PIPELINE_DEEPTH - 1);

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [BEAT_BITS-1:0]   beat_data_q, beat_data_d;
    logic                   beat_sop_q, beat_sop_d;
    logic                   beat_eop_q, beat_eop_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANE_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;

    logic in_accept;
    logic out_accept;

    // A new beat can enter while the last lane of the current one is leaving.
    assign asi_in0_ready = (state_q == EMPTY) | ((cnt_q == LAST_LANE) & aso_out0_ready);
    assign in_accept     = asi_in0_valid & asi_in0_ready;
    assign out_accept    = (state_q == BUSY) & aso_out0_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_data_d = beat_data_q;
        beat_sop_d  = beat_sop_q;
        beat_eop_d  = beat_eop_q;

        case (state_q)
            EMPTY: begin
                if (in_accept) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    beat_data_d = asi_in0_data;
                    beat_sop_d  = asi_in0_startofpacket;
                    beat_eop_d  = asi_in0_endofpacket;
                end
            end
            BUSY: begin
                if (out_accept) begin
                    if (cnt_q != LAST_LANE) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (in_accept) begin
                        cnt_d       = '0;
                        beat_data_d = asi_in0_data;
                        beat_sop_d  = asi_in0_startofpacket;
                        beat_eop_d  = asi_in0_endofpacket;
                    end else begin
                        state_d = EMPTY;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered copies of the lane the next state will present.
        out_valid_d = (state_d == BUSY);
        out_data_d  = beat_data_d[cnt_d * LANE_BITS +: LANE_BITS];
        out_sop_d   = out_valid_d & beat_sop_d & (cnt_d == '0);
        out_eop_d   = out_valid_d & beat_eop_d & (cnt_d == LAST_LANE);
    end

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            beat_data_q <= '0;
            beat_sop_q  <= 1'b0;
            beat_eop_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_data_q <= beat_data_d;
            beat_sop_q  <= beat_sop_d;
            beat_eop_q  <= beat_eop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign aso_out0_valid         = out_valid_q;
    assign aso_out0_data          = out_data_q;
    assign aso_out0_startofpacket = out_sop_q;
    assign aso_out0_endofpacket   = out_eop_q;

endmodule

// File: tb/tb_qam_symbol_serializer.sv
// Self-checking bench for qam_symbol_serializer (8-bit components, 4 lanes per beat).
// Accepted beats expand into expected symbols on a queue; accepted symbols pop and compare.
module tb_qam_symbol_serializer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LW = 2 * W;
    localparam int BW = D * LW;

    logic          clock_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [BW-1:0] asi_in0_data = '0;
    logic          asi_in0_valid = 1'b0;
    logic          asi_in0_ready;
    logic          asi_in0_startofpacket = 1'b0;
    logic          asi_in0_endofpacket = 1'b0;
    logic [LW-1:0] aso_out0_data;
    logic          aso_out0_valid;
    logic          aso_out0_ready = 1'b0;
    logic          aso_out0_startofpacket;
    logic          aso_out0_endofpacket;

    typedef struct packed {
        logic [LW-1:0] data;
        logic          sop;
        logic          eop;
    } sym_t;

    sym_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    qam_symbol_serializer #(
        .MOD_OUT_WIDTH  (W),
        .PIPELINE_DEEPTH(D)
    ) dut (
        .clock_clk             (clock_clk),
        .reset_reset_n         (reset_reset_n),
        .asi_in0_data          (asi_in0_data),
        .asi_in0_valid         (asi_in0_valid),
        .asi_in0_ready         (asi_in0_ready),
        .asi_in0_startofpacket (asi_in0_startofpacket),
        .asi_in0_endofpacket   (asi_in0_endofpacket),
        .aso_out0_data         (aso_out0_data),
        .aso_out0_valid        (aso_out0_valid),
        .aso_out0_ready        (aso_out0_ready),
        .aso_out0_startofpacket(aso_out0_startofpacket),
        .aso_out0_endofpacket  (aso_out0_endofpacket)
    );

    always #5 clock_clk = ~clock_clk;

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    // Scoreboard monitor: samples 2 time units after each falling edge, once inputs have settled.
    logic prev_stall = 1'b0;
    sym_t prev_sym = '0;
    always begin
        @(negedge clock_clk);
        #2;
        if (reset_reset_n !== 1'b1) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (aso_out0_valid !== 1'b1 ||
                    {aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket} !== prev_sym) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%b d=%h s=%b e=%b, need v=1 d=%h s=%b e=%b",
                             aso_out0_valid, aso_out0_data, aso_out0_startofpacket,
                             aso_out0_endofpacket, prev_sym.data, prev_sym.sop, prev_sym.eop);
                end
            end
            if (asi_in0_valid === 1'b1 && asi_in0_ready === 1'b1) begin
                for (int k = 0; k < D; k++) begin
                    sb_q.push_back('{data: asi_in0_data[k*LW +: LW],
                                     sop:  asi_in0_startofpacket && (k == 0),
                                     eop:  asi_in0_endofpacket && (k == D - 1)});
                end
            end
            if (aso_out0_valid === 1'b1 && aso_out0_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got d=%h s=%b e=%b, need no symbol",
                             aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket);
                end else begin
                    sym_t exp_sym;
                    exp_sym = sb_q.pop_front();
                    if ({aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket} !== exp_sym) begin
                        errors++;
                        $display("[TB] FAIL sb_symbol: got d=%h s=%b e=%b, need d=%h s=%b e=%b",
                                 aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket,
                                 exp_sym.data, exp_sym.sop, exp_sym.eop);
                    end
                end
            end
            prev_stall = (aso_out0_valid === 1'b1) && (aso_out0_ready === 1'b0);
            prev_sym   = '{data: aso_out0_data, sop: aso_out0_startofpacket, eop: aso_out0_endofpacket};
        end
    end

    task automatic test_reset();
        reset_reset_n         = 1'b0;
        asi_in0_valid         = 1'b1;
        asi_in0_data          = rand_beat();
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b1;
        aso_out0_ready        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_clk);
            #3;
            checks++;
            if (aso_out0_valid !== 1'b0 || aso_out0_data !== 16'h0 ||
                aso_out0_startofpacket !== 1'b0 || aso_out0_endofpacket !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got v=%b d=%h s=%b e=%b, need v=0 d=0000 s=0 e=0",
                         aso_out0_valid, aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket);
            end
        end
        @(negedge clock_clk);
        reset_reset_n = 1'b1;
        asi_in0_valid = 1'b0;
        #3;
        checks++;
        if (asi_in0_ready !== 1'b1 || aso_out0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got ready=%b v=%b, need ready=1 v=0",
                     asi_in0_ready, aso_out0_valid);
        end
    endtask

    task automatic test_single();
        logic [LW-1:0] exp_lane [D];
        exp_lane = '{16'h40C0, 16'hC0C0, 16'hC040, 16'h4040};
        @(negedge clock_clk);
        asi_in0_valid         = 1'b1;
        asi_in0_data          = 64'h4040_C040_C0C0_40C0;
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b1;
        aso_out0_ready        = 1'b1;
        #3;
        checks++;
        if (asi_in0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_in_ready: got %b, need 1", asi_in0_ready);
        end
        for (int i = 0; i < D; i++) begin
            @(negedge clock_clk);
            asi_in0_valid = 1'b0;
            #3;
            checks++;
            if (aso_out0_valid !== 1'b1 || aso_out0_data !== exp_lane[i] ||
                aso_out0_startofpacket !== (i == 0) || aso_out0_endofpacket !== (i == D - 1)) begin
                errors++;
                $display("[TB] FAIL single_lane%0d: got v=%b d=%h s=%b e=%b, need v=1 d=%h s=%b e=%b",
                         i, aso_out0_valid, aso_out0_data, aso_out0_startofpacket,
                         aso_out0_endofpacket, exp_lane[i], (i == 0), (i == D - 1));
            end
        end
        @(negedge clock_clk);
        #3;
        checks++;
        if (aso_out0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: got v=%b, need v=0", aso_out0_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] beats [3];
        int  b = 0;
        logic accepted;
        for (int i = 0; i < 3; i++) beats[i] = rand_beat();
        @(negedge clock_clk);
        asi_in0_valid         = 1'b1;
        asi_in0_data          = beats[0];
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b0;
        aso_out0_ready        = 1'b1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            #3;
            accepted = asi_in0_valid && asi_in0_ready;
            if (cyc > 0) begin
                int sym;
                sym = cyc - 1;
                checks++;
                if (aso_out0_valid !== 1'b1 || aso_out0_startofpacket !== (sym == 0) ||
                    aso_out0_endofpacket !== (sym == 3 * D - 1)) begin
                    errors++;
                    $display("[TB] FAIL b2b_stream sym%0d: got v=%b s=%b e=%b, need v=1 s=%b e=%b",
                             sym, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
                             (sym == 0), (sym == 3 * D - 1));
                end
                checks++;
                if (asi_in0_ready !== (sym % D == D - 1)) begin
                    errors++;
                    $display("[TB] FAIL b2b_in_ready sym%0d: got %b, need %b",
                             sym, asi_in0_ready, (sym % D == D - 1));
                end
            end
            @(negedge clock_clk);
            if (accepted) begin
                b++;
                if (b < 3) begin
                    asi_in0_data          = beats[b];
                    asi_in0_startofpacket = 1'b0;
                    asi_in0_endofpacket   = (b == 2);
                end else begin
                    asi_in0_valid = 1'b0;
                end
            end
        end
        checks++;
        if (b != 3) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got %0d beats accepted, need 3", b);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] beat;
        beat = rand_beat();
        @(negedge clock_clk);
        asi_in0_valid         = 1'b1;
        asi_in0_data          = beat;
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b1;
        aso_out0_ready        = 1'b1;
        @(negedge clock_clk);
        asi_in0_valid = 1'b0;
        @(negedge clock_clk);
        @(negedge clock_clk);
        aso_out0_ready        = 1'b0;
        asi_in0_valid         = 1'b1;
        asi_in0_data          = rand_beat();
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            checks++;
            if (aso_out0_valid !== 1'b1 || aso_out0_data !== beat[2*LW +: LW] ||
                aso_out0_startofpacket !== 1'b0 || aso_out0_endofpacket !== 1'b0 ||
                asi_in0_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v=%b d=%h s=%b e=%b rdy=%b, need v=1 d=%h s=0 e=0 rdy=0",
                         i, aso_out0_valid, aso_out0_data, aso_out0_startofpacket,
                         aso_out0_endofpacket, asi_in0_ready, beat[2*LW +: LW]);
            end
            @(negedge clock_clk);
        end
        asi_in0_valid  = 1'b0;
        aso_out0_ready = 1'b1;
        #3;
        checks++;
        if (aso_out0_valid !== 1'b1 || aso_out0_data !== beat[2*LW +: LW]) begin
            errors++;
            $display("[TB] FAIL bp_release_lane2: got v=%b d=%h, need v=1 d=%h",
                     aso_out0_valid, aso_out0_data, beat[2*LW +: LW]);
        end
        @(negedge clock_clk);
        #3;
        checks++;
        if (aso_out0_valid !== 1'b1 || aso_out0_data !== beat[3*LW +: LW] ||
            aso_out0_endofpacket !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_lane3: got v=%b d=%h e=%b, need v=1 d=%h e=1",
                     aso_out0_valid, aso_out0_data, aso_out0_endofpacket, beat[3*LW +: LW]);
        end
        @(negedge clock_clk);
        #3;
        checks++;
        if (aso_out0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_idle: got v=%b, need v=0", aso_out0_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [BW-1:0] beat_a, beat_b;
        beat_a = rand_beat();
        beat_b = rand_beat();
        @(negedge clock_clk);
        asi_in0_valid         = 1'b1;
        asi_in0_data          = beat_a;
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b1;
        aso_out0_ready        = 1'b1;
        @(negedge clock_clk);
        asi_in0_data        = beat_b;
        asi_in0_endofpacket = 1'b0;
        for (int i = 0; i < D; i++) begin
            #3;
            if (i == D - 1) begin
                checks++;
                if (asi_in0_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL simul_in_ready: got %b, need 1", asi_in0_ready);
                end
            end
            @(negedge clock_clk);
        end
        asi_in0_valid = 1'b0;
        #3;
        checks++;
        if (aso_out0_valid !== 1'b1 || aso_out0_data !== beat_b[LW-1:0] ||
            aso_out0_startofpacket !== 1'b1 || aso_out0_endofpacket !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_new_lane0: got v=%b d=%h s=%b e=%b, need v=1 d=%h s=1 e=0",
                     aso_out0_valid, aso_out0_data, aso_out0_startofpacket,
                     aso_out0_endofpacket, beat_b[LW-1:0]);
        end
    endtask

    task automatic test_random();
        int   sent = 0;
        int   cyc = 0;
        logic pending = 1'b0;
        while (sent < 1000 && cyc < 40000) begin
            @(negedge clock_clk);
            cyc++;
            if (!pending) begin
                if ($urandom_range(1) == 1) begin
                    asi_in0_valid         = 1'b1;
                    asi_in0_data          = rand_beat();
                    asi_in0_startofpacket = 1'($urandom_range(1));
                    asi_in0_endofpacket   = 1'($urandom_range(1));
                    pending               = 1'b1;
                end else begin
                    asi_in0_valid = 1'b0;
                end
            end
            aso_out0_ready = 1'($urandom_range(1));
            #3;
            if (asi_in0_valid && asi_in0_ready) begin
                sent++;
                pending = 1'b0;
            end
        end
        checks++;
        if (sent != 1000) begin
            errors++;
            $display("[TB] FAIL random_beats: got %0d beats accepted, need 1000", sent);
        end
        @(negedge clock_clk);
        asi_in0_valid  = 1'b0;
        aso_out0_ready = 1'b1;
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clock_clk);
        #3;
        checks++;
        if (sb_q.size() != 0 || aso_out0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_drain: got %0d pending symbols v=%b, need 0 v=0",
                     sb_q.size(), aso_out0_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] beat_x, beat_y;
        beat_x = rand_beat();
        beat_y = rand_beat();
        @(negedge clock_clk);
        asi_in0_valid         = 1'b1;
        asi_in0_data          = beat_x;
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b1;
        aso_out0_ready        = 1'b1;
        @(negedge clock_clk);
        asi_in0_valid = 1'b0;
        @(negedge clock_clk);
        reset_reset_n = 1'b0;
        #3;
        checks++;
        if (aso_out0_valid !== 1'b1 || aso_out0_data !== beat_x[LW +: LW]) begin
            errors++;
            $display("[TB] FAIL mid_lane1: got v=%b d=%h, need v=1 d=%h",
                     aso_out0_valid, aso_out0_data, beat_x[LW +: LW]);
        end
        @(negedge clock_clk);
        reset_reset_n = 1'b1;
        #3;
        checks++;
        if (aso_out0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after_reset: got v=%b, need v=0", aso_out0_valid);
        end
        @(negedge clock_clk);
        asi_in0_valid         = 1'b1;
        asi_in0_data          = beat_y;
        asi_in0_startofpacket = 1'b1;
        asi_in0_endofpacket   = 1'b0;
        #3;
        checks++;
        if (asi_in0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_in_ready: got %b, need 1", asi_in0_ready);
        end
        @(negedge clock_clk);
        asi_in0_valid = 1'b0;
        #3;
        checks++;
        if (aso_out0_valid !== 1'b1 || aso_out0_data !== beat_y[LW-1:0] ||
            aso_out0_startofpacket !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_next_lane0: got v=%b d=%h s=%b, need v=1 d=%h s=1",
                     aso_out0_valid, aso_out0_data, aso_out0_startofpacket, beat_y[LW-1:0]);
        end
        for (int i = 0; i < 8; i++) @(negedge clock_clk);
        #3;
        checks++;
        if (sb_q.size() != 0 || aso_out0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_drain: got %0d pending symbols v=%b, need 0 v=0",
                     sb_q.size(), aso_out0_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
